// File: rtl/odd_parity_pkg.sv
// Shared constants and helpers for the odd-parity checker.
// Optional error counter is enabled with ODD_PARITY_ERR_COUNT_EN.
package odd_parity_pkg;

   localparam int DEFAULT_DATA_W = 4;
   localparam int DEFAULT_CNT_W  = 16;

   // All-ones value for a counter of the given width (up to 64 bits).
   function automatic logic [63:0] sat_limit(input int unsigned width);
      if (width >= 64)
         return '1;
      else
         return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/odd_parity_tree.sv
// Combinational XOR reduction over parity bit plus data.
// err is high when the number of ones is even.
module odd_parity_tree #(
   parameter int W = 5
) (
   input  logic [W-1:0] vec,
   output logic         err
);

   assign err = ~(^vec);

endmodule

// File: rtl/odd_parity_checker.sv
// Registered odd-parity checker with sticky error flag.
// Define ODD_PARITY_ERR_COUNT_EN to add a saturating err_count output.
module odd_parity_checker
   import odd_parity_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data,
   input  logic              odd_parity,
   input  logic              clr_sticky,
   output logic              out_valid,
   output logic              op_check,
   output logic              err_sticky
`ifdef ODD_PARITY_ERR_COUNT_EN
   ,
   output logic [CNT_W-1:0]  err_count
`endif
);

   logic err;
   logic new_err;

   odd_parity_tree #(
      .W(DATA_W + 1)
   ) u_tree (
      .vec({odd_parity, data}),
      .err(err)
   );

   assign new_err = in_valid & err;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         op_check   <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            op_check <= err;
         // A fresh error beats a simultaneous clear.
         if (new_err)
            err_sticky <= 1'b1;
         else if (clr_sticky)
            err_sticky <= 1'b0;
      end
   end

`ifdef ODD_PARITY_ERR_COUNT_EN
   localparam logic [63:0] LIMIT = sat_limit(CNT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = LIMIT[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (new_err && err_count != CNT_MAX)
         err_count <= err_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_odd_parity_checker.sv
// Randomized and directed bench for odd_parity_checker.
// Counter checks run when ODD_PARITY_ERR_COUNT_EN is defined.
module tb_odd_parity_checker;

   localparam int DW = 4;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] data;
   logic          odd_parity;
   logic          clr_sticky;
   logic          out_valid;
   logic          op_check;
   logic          err_sticky;
`ifdef ODD_PARITY_ERR_COUNT_EN
   logic [CW-1:0] err_count;
`endif

   int vectors = 0;
   int fails   = 0;

   logic ev, eo, es;
   int   ec;
   int   pulses;

   odd_parity_checker #(
      .DATA_W(DW),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .data(data),
      .odd_parity(odd_parity),
      .clr_sticky(clr_sticky),
      .out_valid(out_valid),
      .op_check(op_check),
      .err_sticky(err_sticky)
`ifdef ODD_PARITY_ERR_COUNT_EN
      ,
      .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare all outputs.
   task automatic cycle(input logic r, input logic iv,
                        input logic [DW-1:0] d, input logic p,
                        input logic clr);
      logic e;
      rst = r;
      in_valid = iv;
      data = d;
      odd_parity = p;
      clr_sticky = clr;
      @(posedge clk);
      #1;
      e = ($countones({p, d}) % 2) == 0;
      if (r) begin
         ev = 0; eo = 0; es = 0; ec = 0;
      end else begin
         ev = iv;
         if (iv) eo = e;
         if (iv && e) begin
            es = 1;
            if (ec < CMAX) ec = ec + 1;
         end else if (clr) begin
            es = 0;
         end
      end
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("op_check", 32'(op_check), 32'(eo));
      chk("err_sticky", 32'(err_sticky), 32'(es));
`ifdef ODD_PARITY_ERR_COUNT_EN
      chk("err_count", 32'(err_count), 32'(ec));
`endif
   endtask

   logic [4:0] spot_v [6];
   logic       spot_e [6];

   initial begin
      ev = 0; eo = 0; es = 0; ec = 0;
      spot_v[0] = 5'b0_0000; spot_e[0] = 1;
      spot_v[1] = 5'b1_0000; spot_e[1] = 0;
      spot_v[2] = 5'b0_0001; spot_e[2] = 0;
      spot_v[3] = 5'b0_1111; spot_e[3] = 1;
      spot_v[4] = 5'b1_1111; spot_e[4] = 0;
      spot_v[5] = 5'b1_0111; spot_e[5] = 1;

      cycle(1, 0, '0, 0, 0);
      cycle(1, 1, 4'b0000, 0, 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_op", 32'(op_check), 0);
      chk("rst_sticky", 32'(err_sticky), 0);

      for (int i = 0; i < 32; i++) begin
         logic [4:0] v;
         v = 5'(i);
         cycle(0, 1, v[3:0], v[4], 0);
         chk("sweep_valid", 32'(out_valid), 1);
      end

      for (int i = 0; i < 6; i++) begin
         logic [4:0] v;
         v = spot_v[i];
         cycle(0, 1, v[3:0], v[4], 0);
         chk("spot", 32'(op_check), 32'(spot_e[i]));
      end

      pulses = 0;
      cycle(0, 1, 4'b0001, 0, 0);
      pulses += out_valid;
      chk("gap_first", 32'(op_check), 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 4'($urandom), 1'($urandom), 0);
         pulses += out_valid;
         chk("gap_hold", 32'(op_check), 0);
      end
      cycle(0, 1, 4'b0011, 0, 0);
      pulses += out_valid;
      chk("gap_second", 32'(op_check), 1);
      chk("gap_pulses", 32'(pulses), 2);

      cycle(0, 0, '0, 0, 1);
      cycle(0, 1, 4'b0000, 0, 0);
      cycle(0, 1, 4'b0000, 1, 0);
      chk("sticky_hold", 32'(err_sticky), 1);
      cycle(0, 0, 4'($urandom), 0, 1);
      chk("sticky_clr", 32'(err_sticky), 0);
      cycle(0, 1, 4'b0011, 0, 1);
      chk("sticky_win", 32'(err_sticky), 1);

      cycle(1, 1, 4'b0000, 0, 0);
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_op", 32'(op_check), 0);
      chk("midrst_sticky", 32'(err_sticky), 0);

`ifdef ODD_PARITY_ERR_COUNT_EN
      begin
         int exp_cnt [5];
         exp_cnt = '{1, 2, 3, 3, 3};
         for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 4'b0000, 0, 0);
            chk("cnt_seq", 32'(err_count), 32'(exp_cnt[i]));
         end
         cycle(1, 0, '0, 0, 0);
         chk("cnt_rst", 32'(err_count), 0);
      end
`endif

      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 24) == 0),
               1'($urandom),
               4'($urandom),
               1'($urandom),
               ($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/odd_parity_checker.md
Name: odd_parity_checker

Overview:
- Checks odd parity on a DATA_W-bit data word plus one received parity bit.
- Raises op_check when the total count of 1s across {odd_parity, data} is even, which means a parity error.
- Sits at a receive boundary, registered, with one cycle of latency.
- Provides a sticky error flag and, optionally, a saturating error counter for status reporting.

Parameters:
- DATA_W, 4, width of the data word (legal range 1..64).
- CNT_W, 16, width of the error counter (only used when ERR_COUNT_EN is defined).

Ports:
- clk, input, 1, single rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, data and odd_parity are valid this cycle.
- data, input, DATA_W, received data word.
- odd_parity, input, 1, received odd-parity bit.
- clr_sticky, input, 1, clears err_sticky.
- out_valid, output, 1, op_check is valid this cycle.
- op_check, output, 1, 1 = parity error, 0 = no error.
- err_sticky, output, 1, set on any reported error; held until cleared.
- err_count, output, CNT_W, saturating count of errors (present only with ERR_COUNT_EN).

Behaviour:
- Error function: err = ~(^{odd_parity, data}).
  - Odd number of 1s gives err = 0 (no error).
  - Even number of 1s, including all-zero, gives err = 1 (error).
- Latency: one cycle.
  - If in_valid is sampled high at edge N, then at edge N out_valid <= 1 and op_check <= err.
  - If in_valid is low, out_valid <= 0 and op_check holds its last value.
  - Fully pipelined: a new input may be accepted every cycle. There is no backpressure.
- err_sticky:
  - Set on the same edge that op_check is loaded with 1.
  - Cleared at an edge where clr_sticky = 1 and no new error is being loaded.
  - If clr_sticky and a new error occur in the same cycle, set wins and err_sticky = 1.
- Reset: when rst is high at an edge, out_valid = 0, op_check = 0, err_sticky = 0, err_count = 0.
  - Reset overrides in_valid and clr_sticky.
  - Reset mid-stream discards the pending result; no out_valid pulse is produced for it.
- No X propagation: when in_valid = 0, the data and odd_parity inputs are don't-care and must not affect any state.
- DATA_W = 1 is legal: the check covers 2 bits.

Optional Feature:
- Macro: ODD_PARITY_ERR_COUNT_EN.
- Defined:
  - err_count port exists.
  - It increments by 1 on every edge where op_check is loaded with 1.
  - It saturates at 2^CNT_W - 1 and never wraps.
  - It is cleared only by rst.
- Undefined:
  - No err_count port and no counter logic.
  - All other behaviour is identical.

Decomposition:
- Package odd_parity_pkg holds:
  - constant DEFAULT_DATA_W = 4;
  - constant DEFAULT_CNT_W = 16;
  - a function returning the saturation limit for a given counter width.
- Sub-module odd_parity_tree: purely combinational XOR reduction of a (DATA_W+1)-bit vector, producing err.
- The top level contains the registers, sticky flag and optional counter.

Test Plan:
- Exhaustive sweep of all 32 {odd_parity, data} values with DATA_W = 4, in_valid = 1 every cycle. Spot checks:
  - {0, 0000} -> op_check = 1 one cycle later.
  - {1, 0000} -> 0.
  - {0, 0001} -> 0.
  - {0, 1111} -> 1.
  - {1, 1111} -> 0.
  - {1, 0111} -> 1.
  - out_valid = 1 on every cycle after the first.
- in_valid gaps: send {0, 0001}, idle 3 cycles with data toggling, then send {0, 0011}.
  - op_check = 0 and holds through the gap.
  - out_valid is pulsed only twice.
  - op_check = 1 after the second input.
- Sticky flag:
  - Error {0, 0000}, then clean data -> err_sticky stays 1.
  - Assert clr_sticky alone -> err_sticky = 0 next cycle.
  - Assert clr_sticky in the same cycle as error {0, 0011} -> err_sticky = 1.
- Reset mid-operation: in_valid = 1 with {0, 0000} and rst = 1 on the same edge.
  - Next cycle: out_valid = 0, op_check = 0, err_sticky = 0.
- Counter (ODD_PARITY_ERR_COUNT_EN, CNT_W = 2): send 5 error words back-to-back.
  - err_count reads 1, 2, 3, 3, 3.
  - After rst, err_count = 0.
